// File: rtl/round_pacer.sv
// Game round controller: turns a GO press into a timed round, paces change pulses
// at a shrinking interval and supplies a non-repeating 0..2 target number.
module round_pacer #(
   parameter int unsigned TICK_DIV         = 50000,
   parameter int unsigned GAME_SEC         = 30,
   parameter int unsigned INIT_INTERVAL_MS = 1000,
   parameter int unsigned MIN_INTERVAL_MS  = 250,
   parameter int unsigned STEP_MS          = 50,
   parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go_btn,
   output logic       start,
   output logic       change,
   output logic [1:0] randNum,
   output logic [6:0] secs_left,
   output logic       round_done
);

   localparam longint unsigned SecClks = 64'(1000) * 64'(TICK_DIV);
   localparam longint unsigned GapMax  = 64'(INIT_INTERVAL_MS) * 64'(TICK_DIV);
   localparam int unsigned     SW      = $clog2(SecClks);
   localparam int unsigned     GW      = $clog2(GapMax + 3);
   localparam int unsigned     IW      = $clog2(INIT_INTERVAL_MS + 1);
   localparam logic [7:0]      SeedEff = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic            sync1_q, sync2_q, prev_q;
   logic [7:0]      lfsr_q;
   logic            start_q, start_d;
   logic            change_q, change_d;
   logic [1:0]      rand_q, rand_d;
   logic [6:0]      secs_q, secs_d;
   logic            done_q, done_d;
   logic [SW-1:0]   sec_cnt_q, sec_cnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [IW-1:0]   interval_q, interval_d;

   logic            go_edge;
   logic [7:0]      lfsr_next;
   logic [1:0]      cand, cand_alt;
   logic            sec_wrap;
   logic [GW-1:0]   gap_load;
   logic [IW-1:0]   iv_next;

   assign go_edge   = sync2_q & ~prev_q;
   assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign cand      = 2'(lfsr_q % 8'd3);
   assign cand_alt  = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
   assign sec_wrap  = (sec_cnt_q == SW'(SecClks - 1));
   assign gap_load  = GW'(interval_q) * GW'(TICK_DIV);

   always_comb begin
      if (32'(interval_q) >= MIN_INTERVAL_MS + STEP_MS) begin
         iv_next = IW'(32'(interval_q) - STEP_MS);
      end else begin
         iv_next = IW'(MIN_INTERVAL_MS);
      end
   end

   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      change_d   = 1'b0;
      rand_d     = rand_q;
      secs_d     = secs_q;
      done_d     = 1'b0;
      sec_cnt_d  = sec_cnt_q;
      gap_d      = gap_q;
      interval_d = interval_q;
      case (state_q)
         StIdle, StDone: begin
            if (go_edge) begin
               state_d    = StRun;
               start_d    = 1'b1;
               secs_d     = 7'(GAME_SEC);
               sec_cnt_d  = '0;
               // First pulse two edges after entry so the LED block is already running
               gap_d      = GW'(2);
               interval_d = IW'(INIT_INTERVAL_MS);
            end
         end
         StRun: begin
            sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + SW'(1);
            if (sec_wrap && secs_q != 7'd0) begin
               secs_d = secs_q - 7'd1;
            end
            if (sec_wrap && secs_q == 7'd1) begin
               // Time-out wins over a pulse due on the same edge
               state_d = StDone;
               start_d = 1'b0;
               done_d  = 1'b1;
            end else if (gap_q == GW'(1)) begin
               change_d   = 1'b1;
               rand_d     = (cand == rand_q) ? cand_alt : cand;
               gap_d      = gap_load;
               interval_d = iv_next;
            end else if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         prev_q     <= 1'b0;
         lfsr_q     <= SeedEff;
         start_q    <= 1'b0;
         change_q   <= 1'b0;
         rand_q     <= 2'd0;
         secs_q     <= 7'(GAME_SEC);
         done_q     <= 1'b0;
         sec_cnt_q  <= '0;
         gap_q      <= '0;
         interval_q <= '0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= go_btn;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         lfsr_q     <= lfsr_next;
         start_q    <= start_d;
         change_q   <= change_d;
         rand_q     <= rand_d;
         secs_q     <= secs_d;
         done_q     <= done_d;
         sec_cnt_q  <= sec_cnt_d;
         gap_q      <= gap_d;
         interval_q <= interval_d;
      end
   end

   assign start      = start_q;
   assign change     = change_q;
   assign randNum    = rand_q;
   assign secs_left  = secs_q;
   assign round_done = done_q;

endmodule

// File: tb/tb_round_pacer.sv
// Randomized bench for round_pacer: a planner pushes every expected output event
// (cycle + value) into a queue; a negedge monitor pops and compares.
module tb_round_pacer;

   localparam int TICK  = 4;
   localparam int GS    = 2;
   localparam int INIT  = 10;
   localparam int MIN   = 4;
   localparam int STEP  = 3;
   localparam int SECC  = 1000 * TICK;
   localparam int TOTAL = GS * SECC;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       go_btn = 1'b0;
   logic       start, change, round_done;
   logic [1:0] randNum;
   logic [6:0] secs_left;

   round_pacer #(
      .TICK_DIV(TICK), .GAME_SEC(GS), .INIT_INTERVAL_MS(INIT),
      .MIN_INTERVAL_MS(MIN), .STEP_MS(STEP), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .go_btn(go_btn), .start(start), .change(change),
      .randNum(randNum), .secs_left(secs_left), .round_done(round_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 start level, 1 change pulse (val=randNum), 2 round_done, 3 secs_left value
   typedef struct {int kind; int at; int val;} ev_t;
   ev_t expq[$];

   int         vectors = 0;
   int         miscompares = 0;
   bit         mon_en = 1'b0;
   logic       prev_start;
   logic [6:0] prev_secs;
   logic [7:0] lfsr_tab [40000];
   int         rst_edge;
   int         m_rand;
   int         m_secs;

   function automatic logic [7:0] lstep(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic push(input int k, input int at, input int v);
      ev_t e;
      e.kind = k; e.at = at; e.val = v;
      expq.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic observe(input int k, input logic [31:0] v);
      ev_t e;
      vectors++;
      if (expq.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected event kind %0d val %0h at cycle %0d", k, v, cyc);
      end else begin
         e = expq.pop_front();
         if (e.kind != k || e.at != cyc || v !== 32'(e.val)) begin
            miscompares++;
            $display("FAIL event: got kind %0d val %0h cycle %0d, expected kind %0d val %0h cycle %0d",
                     k, v, cyc, e.kind, e.val, e.at);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (start !== prev_start) observe(0, 32'(start));
         if (change !== 1'b0) observe(1, 32'(randNum));
         if (round_done !== 1'b0) observe(2, 0);
         if (secs_left !== prev_secs) observe(3, 32'(secs_left));
         prev_start = start;
         prev_secs  = secs_left;
      end
   end

   // Expected events of one round entered at edge e0, limited to edges before cut
   task automatic plan_round(input int e0, input int cut);
      int next_t = e0 + 2;
      int iv     = INIT;
      int cnd;
      for (int c = e0; c <= e0 + TOTAL && c < cut; c++) begin
         if (c == e0) push(0, c, 1);
         if (c == next_t && c < e0 + TOTAL) begin
            cnd    = int'(lfsr_tab[c - rst_edge - 1]) % 3;
            m_rand = (cnd == m_rand) ? (cnd + 1) % 3 : cnd;
            push(1, c, m_rand);
            next_t = next_t + iv * TICK;
            iv     = (iv - STEP < MIN) ? MIN : iv - STEP;
         end
         if (c == e0 + TOTAL) begin
            push(0, c, 0);
            push(2, c, 0);
         end
         if (c == e0 && m_secs != GS) begin
            m_secs = GS;
            push(3, c, m_secs);
         end else if (c > e0 && (c - e0) % SECC == 0 && m_secs > 0) begin
            m_secs--;
            push(3, c, m_secs);
         end
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // GO activity while a round runs; all of it must be ignored
   task automatic jiggle(input int e0);
      while (cyc < e0 + 3000) begin
         go_btn = 1'b1;
         wait_cyc(cyc + int'($urandom_range(1, 20)));
         go_btn = 1'b0;
         wait_cyc(cyc + int'($urandom_range(5, 60)));
      end
   endtask

   initial begin
      int n, e0;
      lfsr_tab[0] = 8'hA5;
      for (int k = 1; k < 40000; k++) lfsr_tab[k] = lstep(lfsr_tab[k - 1]);

      wait_cyc(5);
      check("reset start", 32'(start), 0);
      check("reset change", 32'(change), 0);
      check("reset randNum", 32'(randNum), 0);
      check("reset secs_left", 32'(secs_left), GS);
      check("reset round_done", 32'(round_done), 0);
      rst = 1'b1;
      rst_edge = 5;
      m_rand = 0;
      m_secs = GS;
      prev_start = 1'b0;
      prev_secs = 7'(GS);
      mon_en = 1'b1;

      // Round 1 from IDLE, GO held for 100 cycles
      n = cyc + int'($urandom_range(3, 20));
      wait_cyc(n);
      go_btn = 1'b1;
      e0 = n + 3;
      plan_round(e0, e0 + TOTAL + 1);
      wait_cyc(n + 100);
      go_btn = 1'b0;
      jiggle(e0);
      wait_cyc(e0 + TOTAL + int'($urandom_range(5, 40)));

      // Round 2 from DONE
      n = cyc + int'($urandom_range(3, 30));
      wait_cyc(n);
      go_btn = 1'b1;
      e0 = n + 3;
      plan_round(e0, e0 + TOTAL + 1);
      wait_cyc(n + int'($urandom_range(3, 50)));
      go_btn = 1'b0;
      jiggle(e0);
      wait_cyc(e0 + TOTAL + int'($urandom_range(5, 40)));

      // Round 3 aborted by reset at E0+1000
      n = cyc + int'($urandom_range(3, 30));
      wait_cyc(n);
      go_btn = 1'b1;
      e0 = n + 3;
      plan_round(e0, e0 + 1000);
      push(0, e0 + 1000, 0);
      if (m_secs != GS) begin
         m_secs = GS;
         push(3, e0 + 1000, GS);
      end
      wait_cyc(n + 5);
      go_btn = 1'b0;
      wait_cyc(e0 + 999);
      rst = 1'b0;
      wait_cyc(e0 + 1000);
      check("midreset start", 32'(start), 0);
      check("midreset change", 32'(change), 0);
      check("midreset randNum", 32'(randNum), 0);
      check("midreset secs_left", 32'(secs_left), GS);
      check("midreset round_done", 32'(round_done), 0);
      wait_cyc(e0 + 1002);
      rst = 1'b1;
      rst_edge = e0 + 1002;
      m_rand = 0;
      wait_cyc(cyc + 200);

      // Round 4 after the mid-round reset
      n = cyc + int'($urandom_range(3, 30));
      wait_cyc(n);
      go_btn = 1'b1;
      e0 = n + 3;
      plan_round(e0, e0 + TOTAL + 1);
      wait_cyc(n + int'($urandom_range(3, 50)));
      go_btn = 1'b0;
      jiggle(e0);
      wait_cyc(e0 + TOTAL + 20);

      check("pending events", 32'(expq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
